// File: rtl/ex_counter.sv
// Free-running up-counter with count enable and synchronous clear.
// Define EX_COUNTER_SAT_EN to saturate at all-ones instead of wrapping.
module ex_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);
  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [WIDTH-1:0] cntNext;

  always_comb begin
    cntNext = cnt;
    if (enable) begin
`ifdef EX_COUNTER_SAT_EN
      // Hold at all-ones once reached; the enable is simply ignored there.
      if (cnt != CntMax) begin
        cntNext = cnt + CntOne;
      end
`else
      cntNext = cnt + CntOne;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cntNext;
    end
  end

endmodule

// File: tb/tb_ex_counter.sv
// Directed self-checking bench for ex_counter (default and EX_COUNTER_SAT_EN builds).
module tb_ex_counter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] cnt;
  logic        rstNarrow;
  logic        enableNarrow;
  logic [3:0]  cntNarrow;

  int vectors;
  int miscompares;

  ex_counter #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .cnt    (cnt)
  );

  ex_counter #(.WIDTH(4)) dutNarrow (
    .clk    (clk),
    .rst    (rstNarrow),
    .enable (enableNarrow),
    .cnt    (cntNarrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs and samples both sit 1 unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    step(1);
    vectors++;
    if (cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_clear: got %0d expected 0", cnt);
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      vectors++;
      if (cnt !== 16'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold edge %0d: got %0d expected 0", i, cnt);
      end
    end
  endtask

  task automatic test_count_hold();
    enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      vectors++;
      if (cnt !== 16'(i)) begin
        miscompares++;
        $display("[TB] FAIL count edge %0d: got %0d expected %0d", i, cnt, i);
      end
    end
    enable = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      step(1);
      if (i % 10 == 0) begin
        vectors++;
        if (cnt !== 16'd10) begin
          miscompares++;
          $display("[TB] FAIL hold edge %0d: got %0d expected 10", i, cnt);
        end
      end
    end
  endtask

  task automatic test_resume();
    enable = 1'b1;
    step(7);
    vectors++;
    if (cnt !== 16'd17) begin
      miscompares++;
      $display("[TB] FAIL resume: got %0d expected 17", cnt);
    end
  endtask

  task automatic test_reset_mid_count();
    step(183);
    vectors++;
    if (cnt !== 16'd200) begin
      miscompares++;
      $display("[TB] FAIL reach_200: got %0d expected 200", cnt);
    end
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      vectors++;
      if (cnt !== 16'd0) begin
        miscompares++;
        $display("[TB] FAIL rst_priority edge %0d: got %0d expected 0", i, cnt);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      vectors++;
      if (cnt !== 16'(i)) begin
        miscompares++;
        $display("[TB] FAIL restart edge %0d: got %0d expected %0d", i, cnt, i);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap_narrow();
    logic [3:0] expected;
    rstNarrow = 1'b1;
    enableNarrow = 1'b0;
    step(1);
    vectors++;
    if (cntNarrow !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL narrow_reset: got %0d expected 0", cntNarrow);
    end
    rstNarrow = 1'b0;
    enableNarrow = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step(1);
`ifdef EX_COUNTER_SAT_EN
      expected = (i >= 15) ? 4'd15 : 4'(i);
`else
      expected = 4'(i % 16);
`endif
      if (i >= 14) begin
        vectors++;
        if (cntNarrow !== expected) begin
          miscompares++;
          $display("[TB] FAIL narrow_wrap edge %0d: got %0d expected %0d", i, cntNarrow, expected);
        end
      end
    end
    enableNarrow = 1'b0;
  endtask

  task automatic test_full_wrap();
    logic [15:0] expected;
    rst = 1'b1;
    enable = 1'b0;
    step(1);
    rst = 1'b0;
    enable = 1'b1;
    step(65535);
    vectors++;
    if (cnt !== 16'hFFFF) begin
      miscompares++;
      $display("[TB] FAIL full_max: got %h expected ffff", cnt);
    end
    step(1);
`ifdef EX_COUNTER_SAT_EN
    expected = 16'hFFFF;
`else
    expected = 16'h0000;
`endif
    vectors++;
    if (cnt !== expected) begin
      miscompares++;
      $display("[TB] FAIL full_wrap: got %h expected %h", cnt, expected);
    end
    rst = 1'b1;
    step(1);
    vectors++;
    if (cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL full_reset: got %h expected 0000", cnt);
    end
    rst = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    enable = 1'b0;
    rstNarrow = 1'b1;
    enableNarrow = 1'b0;
    #2;
    test_reset();
    test_count_hold();
    test_resume();
    test_reset_mid_count();
    test_wrap_narrow();
    test_full_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
